usb_tx_packetizer: RTL
======================

USB_TX_PACKETIZER -- requirements
Module: usb_tx_packetizer

Interface
REQ-001 SHALL have: clk  in  1  system clock; all state changes on rising edge.
REQ-002 SHALL have: n_rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: tx_packet  in  2  PID request from protocol controller (00 IDLE, 01 DATA, 10 ACK, 11 NAK); sampled in IDLE only.
REQ-004 SHALL have: buffer_occupancy  in  7  data buffer byte count.
REQ-005 SHALL have: tx_data  in  8  data buffer read byte, valid the cycle after get_tx_packet_data.
REQ-006 SHALL have: get_tx_packet_data  out  1  one-cycle read strobe to data buffer.
REQ-007 SHALL have: byte_out  out  8  byte to bit encoder, LSB transmitted first.
REQ-008 SHALL have: byte_valid  out  1  byte_out valid; byte_ready  in  1  encoder accepts; transfer on valid&&ready.
REQ-009 SHALL have: eop_req  out  1  request EOP from encoder; eop_done  in  1  one-cycle EOP-complete pulse.
REQ-010 SHALL have: tx_done  out  1  one-cycle packet-complete pulse; tx_busy  out  1  high in every non-IDLE state.

Function
REQ-011 SHALL implement FSM states IDLE, SYNC, PID, FETCH, DATA, CRC_LO, CRC_HI, EOP, DONE.
REQ-012 IDLE: tx_packet != 00 SHALL latch PID and count = min(buffer_occupancy, 64), go to SYNC; tx_packet outside IDLE ignored.
REQ-013 SYNC SHALL present 8'h80; PID SHALL present 8'hC3 (DATA0), 8'hD2 (ACK) or 8'h5A (NAK).
REQ-014 Each byte state SHALL hold byte_out/byte_valid stable until byte_ready; advance on the handshake cycle.
REQ-015 After PID: ACK/NAK go to EOP; DATA with count>0 goes to FETCH; DATA with count==0 goes to CRC_LO.
REQ-016 FETCH SHALL pulse get_tx_packet_data one cycle, decrement count, next state DATA presenting registered tx_data.
REQ-017 DATA handshake SHALL go to FETCH if count>0, else CRC_LO.
REQ-018 CRC16 SHALL use poly 0x8005, init 16'hFFFF, LSB-first update per accepted payload byte; transmitted value inverted, low byte in CRC_LO, high byte in CRC_HI.
REQ-019 EOP SHALL hold eop_req high until eop_done, then DONE; DONE SHALL pulse tx_done one cycle and return to IDLE.
REQ-020 byte_valid SHALL be low in IDLE, FETCH, EOP, DONE; get_tx_packet_data never asserted for ACK/NAK.
REQ-021 Occupancy changes after latching SHALL not affect byte count.

Reset
REQ-022 n_rst low SHALL immediately force IDLE, CRC to 16'hFFFF, count 0, all outputs 0 (byte_out 8'h00), including mid-packet.
REQ-023 First request after reset release SHALL be accepted normally; no partial packet resumes.

Configuration
REQ-024 Macro USB_TX_ZLP_EN defined: DATA with count==0 sends zero-length packet (SYNC, C3, 00, 00, EOP).
REQ-025 Macro USB_TX_ZLP_EN undefined: DATA with count==0 SHALL send NAK PID (5A) instead of DATA0, then EOP; tx_done behaviour unchanged.

Structure
REQ-026 Shared package usb_pkg SHALL hold tx_packet encodings, PID byte constants, SYNC constant, CRC16 polynomial/init, and max payload (64).
REQ-027 CRC16 SHALL be sub-module usb_crc16 (clear, enable, 8-bit data in, 16-bit crc out).
REQ-028 State enum SHALL be local to usb_tx_packetizer.

Verification
REQ-029 ACK: tx_packet=10 one cycle, byte_ready=1 -> bytes 80, D2; eop_req; eop_done -> tx_done pulse next cycle.
REQ-030 NAK with byte_ready low 5 cycles per byte -> byte_out stable 80 then 5A while waiting; exactly two transfers.
REQ-031 DATA, occupancy 3, buffer 01 02 03 -> 3 get strobes; bytes 80, C3, 01, 02, 03, CRC lo/hi equal to software CRC16 model.
REQ-032 DATA, occupancy 0 -> with USB_TX_ZLP_EN: 80, C3, 00, 00; without: 80, 5A; both end with tx_done.
REQ-033 Reset asserted during DATA byte 2 of 10 -> all outputs 0 immediately; next ACK request yields 80, D2 cleanly.
REQ-034 tx_packet=01 pulsed while busy -> ignored; single packet and single tx_done observed.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared constants for the USB transmit packetizer: request encodings, PID/SYNC bytes,
// CRC16 parameters and payload limit.
package usb_pkg;

    typedef enum logic [1:0] {
        PktIdle = 2'b00,
        PktData = 2'b01,
        PktAck  = 2'b10,
        PktNak  = 2'b11
    } tx_packet_e;

    localparam logic [7:0]  SyncByte   = 8'h80;
    localparam logic [7:0]  PidData0   = 8'hC3;
    localparam logic [7:0]  PidAck     = 8'hD2;
    localparam logic [7:0]  PidNak     = 8'h5A;

    localparam logic [15:0] Crc16Poly  = 16'h8005;
    localparam logic [15:0] Crc16Init  = 16'hFFFF;

    localparam logic [6:0]  MaxPayload = 7'd64;

endpackage

// File: rtl/usb_tx_packetizer_if.sv
// Packetizer-side bundle: protocol request, data buffer read port, bit-encoder byte/EOP
// handshake and status. master = packetizer, slave = surrounding logic.
interface usb_tx_packetizer_if;

    logic [1:0] tx_packet;
    logic [6:0] buffer_occupancy;
    logic [7:0] tx_data;
    logic       get_tx_packet_data;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic       eop_req;
    logic       eop_done;
    logic       tx_done;
    logic       tx_busy;

    modport master (
        input  tx_packet,
        input  buffer_occupancy,
        input  tx_data,
        output get_tx_packet_data,
        output byte_out,
        output byte_valid,
        input  byte_ready,
        output eop_req,
        input  eop_done,
        output tx_done,
        output tx_busy
    );

    modport slave (
        output tx_packet,
        output buffer_occupancy,
        output tx_data,
        input  get_tx_packet_data,
        input  byte_out,
        input  byte_valid,
        output byte_ready,
        input  eop_req,
        output eop_done,
        input  tx_done,
        input  tx_busy
    );

endinterface

// File: rtl/usb_crc16.sv
// USB CRC16 accumulator (poly 0x8005, init 0xFFFF), one byte per enabled cycle, bit 0 first.
module usb_crc16
    import usb_pkg::*;
(
    input  logic        clk_i,
    input  logic        n_rst_i,
    input  logic        clear_i,
    input  logic        enable_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q, crc_d, step;

    always_comb begin
        step = crc_q;
        for (int i = 0; i < 8; i++) begin
            if (step[15] ^ data_i[i]) begin
                step = {step[14:0], 1'b0} ^ Crc16Poly;
            end else begin
                step = {step[14:0], 1'b0};
            end
        end
        crc_d = crc_q;
        if (clear_i) begin
            crc_d = Crc16Init;
        end else if (enable_i) begin
            crc_d = step;
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            crc_q <= Crc16Init;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/usb_tx_packetizer.sv
// USB transmit packetizer: SYNC, PID, payload fetched from the data buffer, CRC16, EOP.
// Build option USB_TX_ZLP_EN: an empty DATA request sends a zero-length DATA0 instead of NAK.
module usb_tx_packetizer
    import usb_pkg::*;
(
    input logic                 clk,
    input logic                 n_rst,
    usb_tx_packetizer_if.master bus_io
);

`ifdef USB_TX_ZLP_EN
    localparam bit ZlpEn = 1'b1;
`else
    localparam bit ZlpEn = 1'b0;
`endif

    typedef enum logic [3:0] {
        StIdle, StSync, StPid, StFetch, StData, StCrcLo, StCrcHi, StEop, StDone
    } state_e;

    state_e      state_q;
    logic [6:0]  count_q;
    logic [7:0]  pid_q;
    logic [7:0]  data_q;
    logic        first_q;

    logic [6:0]  occ_clamped;
    logic [7:0]  data_byte;
    logic [15:0] crc;
    logic        crc_clr;
    logic        crc_en;

    assign occ_clamped = (bus_io.buffer_occupancy > MaxPayload) ? MaxPayload
                                                                 : bus_io.buffer_occupancy;

    // Buffer output is live on the first DATA cycle; later cycles hold the captured copy.
    assign data_byte = first_q ? bus_io.tx_data : data_q;

    assign crc_clr = (state_q == StIdle);
    assign crc_en  = (state_q == StData) && bus_io.byte_ready;

    usb_crc16 u_crc16 (
        .clk_i    (clk),
        .n_rst_i  (n_rst),
        .clear_i  (crc_clr),
        .enable_i (crc_en),
        .data_i   (data_byte),
        .crc_o    (crc)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StIdle;
            count_q <= '0;
            pid_q   <= '0;
            data_q  <= '0;
            first_q <= 1'b0;
        end else begin
            first_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus_io.tx_packet != PktIdle) begin
                        count_q <= occ_clamped;
                        state_q <= StSync;
                        if (bus_io.tx_packet == PktData) begin
                            pid_q <= (occ_clamped == '0 && !ZlpEn) ? PidNak : PidData0;
                        end else if (bus_io.tx_packet == PktAck) begin
                            pid_q <= PidAck;
                        end else begin
                            pid_q <= PidNak;
                        end
                    end
                end
                StSync: begin
                    if (bus_io.byte_ready) state_q <= StPid;
                end
                StPid: begin
                    if (bus_io.byte_ready) begin
                        if (pid_q != PidData0) begin
                            state_q <= StEop;
                        end else if (count_q != '0) begin
                            state_q <= StFetch;
                        end else begin
                            state_q <= StCrcLo;
                        end
                    end
                end
                StFetch: begin
                    count_q <= count_q - 7'd1;
                    first_q <= 1'b1;
                    state_q <= StData;
                end
                StData: begin
                    if (first_q) data_q <= bus_io.tx_data;
                    if (bus_io.byte_ready) begin
                        state_q <= (count_q != '0) ? StFetch : StCrcLo;
                    end
                end
                StCrcLo: begin
                    if (bus_io.byte_ready) state_q <= StCrcHi;
                end
                StCrcHi: begin
                    if (bus_io.byte_ready) state_q <= StEop;
                end
                StEop: begin
                    if (bus_io.eop_done) state_q <= StDone;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Outputs decode straight from the state register, so they drop with the async reset.
    always_comb begin
        bus_io.byte_out           = 8'h00;
        bus_io.byte_valid         = 1'b0;
        bus_io.get_tx_packet_data = 1'b0;
        bus_io.eop_req            = 1'b0;
        bus_io.tx_done            = 1'b0;
        bus_io.tx_busy            = (state_q != StIdle);
        unique case (state_q)
            StSync: begin
                bus_io.byte_out   = SyncByte;
                bus_io.byte_valid = 1'b1;
            end
            StPid: begin
                bus_io.byte_out   = pid_q;
                bus_io.byte_valid = 1'b1;
            end
            StFetch: bus_io.get_tx_packet_data = 1'b1;
            StData: begin
                bus_io.byte_out   = data_byte;
                bus_io.byte_valid = 1'b1;
            end
            StCrcLo: begin
                bus_io.byte_out   = ~crc[7:0];
                bus_io.byte_valid = 1'b1;
            end
            StCrcHi: begin
                bus_io.byte_out   = ~crc[15:8];
                bus_io.byte_valid = 1'b1;
            end
            StEop:   bus_io.eop_req = 1'b1;
            StDone:  bus_io.tx_done = 1'b1;
            default: ;
        endcase
    end

endmodule
